// File: rtl/lab2_proc_int_mul_iter.sv
// lab2_proc_int_mul_iter: iterative shift-add 32x32 multiplier returning the low product word
// over val/rdy request and response interfaces.
module lab2_proc_int_mul_iter #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic [63:0] req_msg,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic [31:0] resp_msg
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        last;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end
    // The iteration that consumes the last remaining multiplier bit is the final one.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        last     = (cnt_q == 6'd31) || (EARLY_EXIT && (b_q[31:1] == 31'd0));
        case (state_q)
            IDLE: if (req_val) begin
                a_d      = req_msg[63:32];
                b_d      = req_msg[31:0];
                result_d = '0;
                cnt_d    = '0;
                state_d  = CALC;
            end
            CALC: begin
                result_d = b_q[0] ? result_q + a_q : result_q;
                a_d      = a_q << 1;
                b_d      = b_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                state_d  = last ? DONE : CALC;
            end
            DONE: state_d = resp_rdy ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    assign req_rdy  = reset && (state_q == IDLE);
    assign resp_val = reset && (state_q == DONE);
    assign resp_msg = result_q;
endmodule
